// File: rtl/bounce_gen_pkg.sv
// Shared definitions for the bounce generator: FSM states, LFSR polynomial and
// the small arithmetic helpers used by the generator and its LFSR.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_TOGGLE_GAP = 2'd1,
    ST_SETTLE     = 2'd2
  } state_e;

  localparam int unsigned LFSR_W        = 16;
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  // One step of the right-shifting Galois LFSR; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ LFSR_MASK;
    end
    return r;
  endfunction

  // 16-bit unsigned add clamped at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit Galois LFSR that advances only when step is high. A zero seed is
// replaced so the register can never lock up at zero.
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_ZERO_SUB : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED_EFF;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// Turns a level command into a pseudo-random burst of contact bounces that
// ends on the commanded level, then pulses done after a stable settle window.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int unsigned BOUNCE_BITS = 3,
  parameter int unsigned GAP_BITS    = 4,
  parameter logic [15:0] MIN_GAP     = 16'd4,
  parameter logic [15:0] SETTLE_CNT  = 16'd1000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic sig_out,
  output logic busy,
  output logic done
);

  localparam int unsigned REM_W       = BOUNCE_BITS + 2;
  localparam logic [15:0] SETTLE_EFF  = (SETTLE_CNT == 16'd0) ? 16'd1 : SETTLE_CNT;
  localparam logic [15:0] SETTLE_LAST = SETTLE_EFF - 16'd1;

  state_e            state;
  logic [REM_W-1:0]  rem;
  logic [15:0]       cnt;
  logic [15:0]       lfsr_q;

  logic              accept_c;
  logic              toggle_now_c;
  logic              lfsr_step_c;
  logic [REM_W-1:0]  toggles_c;
  logic [15:0]       gap_rand_c;
  logic [15:0]       gap_c;
  logic              unused_lfsr_c;

  assign accept_c     = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign toggle_now_c = (state == ST_TOGGLE_GAP) && (cnt == 16'd0);
  assign lfsr_step_c  = accept_c || toggle_now_c;

  // Toggle count is always odd (2n+1), so the burst ends on the new level.
  generate
    if (BOUNCE_BITS == 0) begin : g_no_bounce
      assign toggles_c = REM_W'(1);
    end else begin : g_bounce
      assign toggles_c = REM_W'({lfsr_q[BOUNCE_BITS-1:0], 1'b1});
    end
  endgenerate

  generate
    if (GAP_BITS == 0) begin : g_fixed_gap
      assign gap_rand_c = 16'd0;
    end else begin : g_rand_gap
      assign gap_rand_c = 16'(lfsr_q[GAP_BITS-1:0]);
    end
  endgenerate

  assign gap_c         = sat_add16(MIN_GAP, gap_rand_c);
  assign unused_lfsr_c = ^lfsr_q;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .step(lfsr_step_c),
    .q   (lfsr_q)
  );

  // cnt counts down to the next toggle in TOGGLE_GAP and to done in SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rem       <= '0;
      cnt       <= 16'd0;
      sig_out   <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_level == sig_out) begin
              state <= ST_SETTLE;
              cnt   <= SETTLE_EFF;
            end else begin
              state <= ST_TOGGLE_GAP;
              rem   <= toggles_c;
              cnt   <= 16'd0;
            end
          end
        end
        ST_TOGGLE_GAP: begin
          if (toggle_now_c) begin
            sig_out <= ~sig_out;
            rem     <= rem - REM_W'(1);
            if (rem == REM_W'(1)) begin
              state <= ST_SETTLE;
              cnt   <= SETTLE_LAST;
            end else begin
              cnt <= gap_c - 16'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt == 16'd0) begin
            state     <= ST_IDLE;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: a minimal-bounce instance with hand-timed
// events and a default instance checked against a reference LFSR event model.
module tb_bounce_gen;

  localparam int          SETTLE = 1000;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_level, cmd_ready, sig_out, busy, done;
  logic d0_valid, d0_level, d0_ready, d0_sig, d0_busy, d0_done;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int cyc;
    bit is_done;
    bit lvl;
  } ev_t;

  ev_t exp_q[$];
  ev_t exp0_q[$];

  logic [15:0] m_lfsr;
  bit          m_sig;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bounce_gen #(
    .BOUNCE_BITS(3), .GAP_BITS(4), .MIN_GAP(16'd4),
    .SETTLE_CNT(16'(SETTLE)), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_level(cmd_level),
    .cmd_ready(cmd_ready), .sig_out(sig_out), .busy(busy), .done(done)
  );

  bounce_gen #(
    .BOUNCE_BITS(0), .GAP_BITS(0), .MIN_GAP(16'd4),
    .SETTLE_CNT(16'd10), .LFSR_SEED(SEED)
  ) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(d0_valid), .cmd_level(d0_level),
    .cmd_ready(d0_ready), .sig_out(d0_sig), .busy(d0_busy), .done(d0_done)
  );

  // One accept per ready window: ready must drop on the edge after an accept.
  assert property (@(posedge clk) disable iff (rst) (cmd_valid && cmd_ready) |=> (!cmd_ready && busy));
  assert property (@(posedge clk) disable iff (rst) (d0_valid && d0_ready) |=> (!d0_ready && d0_busy));
  assert property (@(posedge clk) busy == !cmd_ready);

  function automatic ev_t mk(input int c, input bit d, input bit l);
    ev_t e;
    e.cyc = c;
    e.is_done = d;
    e.lvl = l;
    return e;
  endfunction

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic cmp_ev(input string nm, input ev_t e, input int c, input bit d,
                        input bit s, input bit r, input bit b);
    compared++;
    if (c != e.cyc || d != e.is_done || s != e.lvl || r != e.is_done || b != !e.is_done) begin
      mismatched++;
      $display("FAIL %s: got edge=%0d done=%0b sig=%0b ready=%0b busy=%0b, expected edge=%0d done=%0b sig=%0b ready=%0b busy=%0b",
               nm, c, d, s, r, b, e.cyc, e.is_done, e.lvl, e.is_done, !e.is_done);
    end
  endtask

  // Reference model: queue every toggle and the done pulse for a command accepted at edge k.
  task automatic push_cmd(input int k, input bit lvl, output int done_edge);
    int n, t, gap;
    bit lv;
    if (lvl == m_sig) begin
      m_lfsr = ref_step(m_lfsr);
      done_edge = k + 1 + SETTLE;
    end else begin
      n = int'(m_lfsr[2:0]);
      m_lfsr = ref_step(m_lfsr);
      t = k + 1;
      lv = m_sig;
      for (int i = 0; i < 2 * n + 1; i++) begin
        lv = !lv;
        exp_q.push_back(mk(t, 1'b0, lv));
        gap = 4 + int'(m_lfsr[3:0]);
        m_lfsr = ref_step(m_lfsr);
        if (i < 2 * n) t += gap;
      end
      done_edge = t + SETTLE;
      m_sig = lv;
    end
    exp_q.push_back(mk(done_edge, 1'b1, lvl));
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Flip cmd_level every cycle while the command is in flight; it must be ignored.
  task automatic wiggle_until(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cmd_level = ~cmd_level;
    end
  endtask

  initial begin : mon_main
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst !== 1'b0) begin
        prev = sig_out;
      end else begin
        if (sig_out != prev || done) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL main_event: got edge=%0d done=%0b sig=%0b, expected no event", cyc, done, sig_out);
          end else begin
            cmp_ev("main_event", exp_q.pop_front(), cyc, done, sig_out, cmd_ready, busy);
          end
        end
        prev = sig_out;
      end
    end
  end

  initial begin : mon_dut0
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst !== 1'b0) begin
        prev = d0_sig;
      end else begin
        if (d0_sig != prev || d0_done) begin
          if (exp0_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL dut0_event: got edge=%0d done=%0b sig=%0b, expected no event", cyc, d0_done, d0_sig);
          end else begin
            cmp_ev("dut0_event", exp0_q.pop_front(), cyc, d0_done, d0_sig, d0_ready, d0_busy);
          end
        end
        prev = d0_sig;
      end
    end
  end

  initial begin : stim
    int k, d_edge, c0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_level = 1'b0;
    d0_valid = 1'b0;
    d0_level = 1'b0;
    m_lfsr = SEED;
    m_sig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sig_out", sig_out, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_d0_ready", d0_ready, 1);
    chk("reset_d0_sig", d0_sig, 0);

    // Minimal instance: single toggle, settle 10, then back-to-back and equal-level commands.
    c0 = cyc + 1;
    d0_valid = 1'b1;
    d0_level = 1'b1;
    exp0_q.push_back(mk(c0 + 1, 1'b0, 1'b1));
    exp0_q.push_back(mk(c0 + 11, 1'b1, 1'b1));
    exp0_q.push_back(mk(c0 + 13, 1'b0, 1'b0));
    exp0_q.push_back(mk(c0 + 23, 1'b1, 1'b0));
    exp0_q.push_back(mk(c0 + 35, 1'b1, 1'b0));
    wait_cyc(c0 + 5);
    d0_level = 1'b0;
    wait_cyc(c0 + 11);
    d0_level = 1'b0;
    wait_cyc(c0 + 16);
    d0_level = 1'b1;
    wait_cyc(c0 + 23);
    d0_level = 1'b0;
    wait_cyc(c0 + 24);
    d0_valid = 1'b0;
    wait_cyc(c0 + 40);

    // Default instance: reset in the middle of the first gap.
    cmd_valid = 1'b1;
    cmd_level = 1'b1;
    k = cyc + 1;
    push_cmd(k, 1'b1, d_edge);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_cyc(k + 2);
    rst = 1'b1;
    #1;
    chk("midrst_sig_out", sig_out, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    exp_q.delete();
    m_lfsr = SEED;
    m_sig = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Replay from seed, then an equal-level command, then 8 alternating commands back-to-back.
    cmd_valid = 1'b1;
    cmd_level = 1'b1;
    k = cyc + 1;
    push_cmd(k, 1'b1, d_edge);
    wiggle_until(d_edge);
    cmd_level = 1'b1;
    push_cmd(d_edge + 1, 1'b1, d_edge);
    for (int j = 0; j < 8; j++) begin
      wiggle_until(d_edge);
      cmd_level = ((j % 2) == 1);
      push_cmd(d_edge + 1, ((j % 2) == 1), d_edge);
    end
    wiggle_until(d_edge);
    cmd_valid = 1'b0;
    wait_cyc(d_edge + 5);

    chk("main_queue_drained", exp_q.size(), 0);
    chk("dut0_queue_drained", exp0_q.size(), 0);
    chk("final_sig_out", sig_out, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
